// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: arbitrates memory stalls, load-use hazards,
// branch redirects and halt drain, and keeps saturating stall/flush counters.
module hazard_stall_controller #(
  parameter int REG_W          = 3,
  parameter int CNT_W          = 16,
  parameter int LOADUSE_CYCLES = 1,
  parameter int DRAIN_CYCLES   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_valid,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_valid,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             branch_taken,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_id,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN = 2'd0, LU = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} state_t;

  state_t     state, state_nxt;
  logic [2:0] lu_cnt, lu_cnt_nxt;
  logic [2:0] drain_cnt, drain_cnt_nxt;
  logic       stall_inc, flush_inc;
  logic       lu_haz;

  assign lu_haz = idex_memread &
                  ((id_rs_valid & (id_rs == idex_rd)) | (id_rt_valid & (id_rt == idex_rd)));

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    halted        = 1'b0;
    state_nxt     = state;
    lu_cnt_nxt    = lu_cnt;
    drain_cnt_nxt = drain_cnt;
    flush_inc     = 1'b0;
    stall_inc     = 1'b0;
    if (rst) begin
      if_id_flush   = 1'b1;
      state_nxt     = RUN;
      lu_cnt_nxt    = 3'd0;
      drain_cnt_nxt = 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (dmem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
          end else if (lu_haz) begin
            // Operands not ready: branch and halt decisions in ID are not trusted yet.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOADUSE_CYCLES > 1) begin
              state_nxt  = LU;
              lu_cnt_nxt = 3'(LOADUSE_CYCLES - 1);
            end else begin
              state_nxt  = RUN;
            end
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (halt_id) begin
            pc_en         = 1'b0;
            if_id_flush   = 1'b1;
            state_nxt     = DRAIN;
            drain_cnt_nxt = 3'(DRAIN_CYCLES);
          end else if (imem_stall) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end else begin
            pc_en = 1'b1;
          end
        end
        LU: begin
          if (dmem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            lu_cnt_nxt   = lu_cnt - 3'd1;
            if (lu_cnt == 3'd1) begin
              state_nxt = RUN;
            end else begin
              state_nxt = LU;
            end
          end
        end
        DRAIN: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          if (dmem_stall) begin
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
          end else begin
            drain_cnt_nxt = drain_cnt - 3'd1;
            if (drain_cnt == 3'd1) begin
              state_nxt = HALTED;
            end else begin
              state_nxt = DRAIN;
            end
          end
        end
        HALTED: begin
          halted      = 1'b1;
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
      stall_inc = ~pc_en & ((state == RUN) | (state == LU));
    end
  end

  // State, down-counters and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      lu_cnt      <= 3'd0;
      drain_cnt   <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state     <= state_nxt;
      lu_cnt    <= lu_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (stall_inc && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end else begin
        stall_count <= stall_count;
      end
      if (flush_inc && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + CNT_W'(1);
      end else begin
        flush_count <= flush_count;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: three controller configurations share one stimulus stream;
// a behavioural model pushes expected outputs, the negedge sampler pops and compares.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst, id_rs_valid, id_rt_valid, idex_memread;
  logic       branch_taken, imem_stall, dmem_stall, halt_id;
  logic [2:0] id_rs, id_rt, idex_rd;

  logic [6:0]  o_dut [3];
  logic [15:0] sc_dut [3];
  logic [15:0] fc_dut [3];

  logic        pc0, ie0, fl0, bb0, em0, mw0, hl0;
  logic        pc1, ie1, fl1, bb1, em1, mw1, hl1;
  logic        pc2, ie2, fl2, bb2, em2, mw2, hl2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  always #5 clk = ~clk;

  hazard_stall_controller #(.REG_W(3), .CNT_W(16), .LOADUSE_CYCLES(1), .DRAIN_CYCLES(3)) u0 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_valid(id_rs_valid), .id_rt(id_rt),
    .id_rt_valid(id_rt_valid), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .halt_id(halt_id), .pc_en(pc0), .if_id_en(ie0), .if_id_flush(fl0), .id_ex_bubble(bb0),
    .ex_mem_en(em0), .mem_wb_en(mw0), .halted(hl0), .stall_count(sc0), .flush_count(fc0));

  hazard_stall_controller #(.REG_W(3), .CNT_W(16), .LOADUSE_CYCLES(3), .DRAIN_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_valid(id_rs_valid), .id_rt(id_rt),
    .id_rt_valid(id_rt_valid), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .halt_id(halt_id), .pc_en(pc1), .if_id_en(ie1), .if_id_flush(fl1), .id_ex_bubble(bb1),
    .ex_mem_en(em1), .mem_wb_en(mw1), .halted(hl1), .stall_count(sc1), .flush_count(fc1));

  hazard_stall_controller #(.REG_W(3), .CNT_W(4), .LOADUSE_CYCLES(2), .DRAIN_CYCLES(5)) u2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_valid(id_rs_valid), .id_rt(id_rt),
    .id_rt_valid(id_rt_valid), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .halt_id(halt_id), .pc_en(pc2), .if_id_en(ie2), .if_id_flush(fl2), .id_ex_bubble(bb2),
    .ex_mem_en(em2), .mem_wb_en(mw2), .halted(hl2), .stall_count(sc2), .flush_count(fc2));

  assign o_dut[0]  = {pc0, ie0, fl0, bb0, em0, mw0, hl0};
  assign o_dut[1]  = {pc1, ie1, fl1, bb1, em1, mw1, hl1};
  assign o_dut[2]  = {pc2, ie2, fl2, bb2, em2, mw2, hl2};
  assign sc_dut[0] = sc0;
  assign sc_dut[1] = sc1;
  assign sc_dut[2] = {12'd0, sc2};
  assign fc_dut[0] = fc0;
  assign fc_dut[1] = fc1;
  assign fc_dut[2] = {12'd0, fc2};

  typedef struct {
    logic [6:0] o;
    int         sc;
    int         fc;
  } exp_t;
  exp_t exp_q [$];

  int total = 0;
  int bad   = 0;

  // Model state per configuration: 0=RUN 1=LU 2=DRAIN 3=HALTED.
  int lucyc [3] = '{1, 3, 2};
  int drc   [3] = '{3, 3, 5};
  int cmax  [3] = '{65535, 65535, 15};
  int m_st [3], m_lu [3], m_dr [3], m_sc [3], m_fc [3];
  int n_st [3], n_lu [3], n_dr [3], n_sc [3], n_fc [3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Output bit order: {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en, halted}
  task automatic model(input int k, output logic [6:0] o);
    bit haz;
    haz = idex_memread && ((id_rs_valid && id_rs == idex_rd) || (id_rt_valid && id_rt == idex_rd));
    n_st[k] = m_st[k]; n_lu[k] = m_lu[k]; n_dr[k] = m_dr[k];
    n_sc[k] = m_sc[k]; n_fc[k] = m_fc[k];
    if (rst) begin
      o = 7'b1110110;
      n_st[k] = 0; n_lu[k] = 0; n_dr[k] = 0; n_sc[k] = 0; n_fc[k] = 0;
      return;
    end
    if (m_st[k] == 0) begin
      if (dmem_stall) o = 7'b0000000;
      else if (haz) begin
        o = 7'b0001110;
        if (lucyc[k] > 1) begin n_st[k] = 1; n_lu[k] = lucyc[k] - 1; end
      end else if (branch_taken) begin
        o = 7'b1110110;
        if (m_fc[k] < cmax[k]) n_fc[k] = m_fc[k] + 1;
      end else if (halt_id) begin
        o = 7'b0110110; n_st[k] = 2; n_dr[k] = drc[k];
      end else if (imem_stall) o = 7'b0110110;
      else o = 7'b1100110;
    end else if (m_st[k] == 1) begin
      if (dmem_stall) o = 7'b0000000;
      else begin
        o = 7'b0001110;
        n_lu[k] = m_lu[k] - 1;
        if (m_lu[k] == 1) n_st[k] = 0;
      end
    end else if (m_st[k] == 2) begin
      if (dmem_stall) o = 7'b0110000;
      else begin
        o = 7'b0110110;
        n_dr[k] = m_dr[k] - 1;
        if (m_dr[k] == 1) n_st[k] = 3;
      end
    end else begin
      o = 7'b0110111;
    end
    if (m_st[k] <= 1 && o[6] == 1'b0 && m_sc[k] < cmax[k]) n_sc[k] = m_sc[k] + 1;
  endtask

  // One clock: push expectations for current inputs, compare at negedge, advance model.
  task automatic cyc();
    exp_t e;
    logic [6:0] o;
    for (int k = 0; k < 3; k++) begin
      model(k, o);
      e.o = o; e.sc = m_sc[k]; e.fc = m_fc[k];
      exp_q.push_back(e);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (exp_q.size() == 0) begin
        check_val("queue_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val($sformatf("outs%0d", k), {25'd0, o_dut[k]}, {25'd0, e.o});
        check_val($sformatf("stall_count%0d", k), {16'd0, sc_dut[k]}, e.sc);
        check_val($sformatf("flush_count%0d", k), {16'd0, fc_dut[k]}, e.fc);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      m_st[k] = n_st[k]; m_lu[k] = n_lu[k]; m_dr[k] = n_dr[k];
      m_sc[k] = n_sc[k]; m_fc[k] = n_fc[k];
    end
  endtask

  task automatic idle();
    id_rs = 3'd0; id_rs_valid = 1'b0; id_rt = 3'd0; id_rt_valid = 1'b0;
    idex_memread = 1'b0; idex_rd = 3'd0; branch_taken = 1'b0;
    imem_stall = 1'b0; dmem_stall = 1'b0; halt_id = 1'b0;
  endtask

  task automatic load_use_rs();
    idle();
    idex_memread = 1'b1; idex_rd = 3'd3; id_rs = 3'd3; id_rs_valid = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_lu[k] = 0; m_dr[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(); cyc();
    rst = 1'b0;
    repeat (2) cyc();

    load_use_rs(); cyc();
    idle(); repeat (4) cyc();

    // rt path, and rs match masked by rs_valid=0
    idle(); idex_memread = 1'b1; idex_rd = 3'd0; id_rt = 3'd0; id_rt_valid = 1'b1; cyc();
    idle(); repeat (3) cyc();
    idle(); idex_memread = 1'b1; idex_rd = 3'd5; id_rs = 3'd5; id_rt = 3'd2; id_rt_valid = 1'b1; cyc();
    idle(); cyc();

    load_use_rs(); branch_taken = 1'b1; cyc();
    idle(); repeat (3) cyc();

    idle(); dmem_stall = 1'b1; branch_taken = 1'b1; cyc();
    idle(); branch_taken = 1'b1; imem_stall = 1'b1; cyc();
    idle(); branch_taken = 1'b1; cyc();

    // dmem stall in the middle of an extended load-use stall
    load_use_rs(); cyc();
    idle(); dmem_stall = 1'b1; cyc();
    idle(); repeat (3) cyc();

    idle(); imem_stall = 1'b1; repeat (20) cyc();
    check_val("sat_stall_cnt4", {28'd0, sc2}, 32'd15);
    idle(); cyc();

    for (int i = 0; i < 120; i++) begin
      id_rs = 3'($urandom_range(0, 3)); id_rt = 3'($urandom_range(0, 3));
      idex_rd = 3'($urandom_range(0, 3));
      id_rs_valid = 1'($urandom_range(0, 1)); id_rt_valid = 1'($urandom_range(0, 1));
      idex_memread = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      imem_stall = ($urandom_range(0, 3) == 0);
      dmem_stall = ($urandom_range(0, 5) == 0);
      halt_id = 1'b0;
      cyc();
    end
    idle(); repeat (4) cyc();

    idle(); halt_id = 1'b1; cyc();
    idle(); dmem_stall = 1'b1; cyc();
    idle(); halt_id = 1'b1; branch_taken = 1'b1; repeat (8) cyc();
    check_val("halted_final0", {31'd0, hl0}, 32'd1);
    check_val("halted_final2", {31'd0, hl2}, 32'd1);
    idle(); rst = 1'b1; cyc();
    rst = 1'b0; repeat (2) cyc();
    check_val("run_after_rst", {25'd0, o_dut[0]}, {25'd0, 7'b1100110});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage 16-bit core.
- Drives the PC write enable, the IF/ID latch enable and NOP-flush, the ID/EX bubble, and the EX/MEM and MEM/WB enables.
- Arbitrates four stall/flush sources by fixed priority: data-memory stall, load-use hazard, ID-resolved branch/jump, instruction-memory stall.
- Also sequences halt drain and keeps saturating stall and flush counters.

Parameters:
REG_W, 3, register specifier width
CNT_W, 16, width of each performance counter
LOADUSE_CYCLES, 1, stall cycles per load-use hazard; legal range 1..7
DRAIN_CYCLES, 3, cycles after halt before `halted` asserts; legal range 1..7

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
id_rs  input  REG_W  source register 1 of instruction in ID
id_rs_valid  input  1  id_rs is actually read
id_rt  input  REG_W  source register 2 of instruction in ID
id_rt_valid  input  1  id_rt is actually read
idex_memread  input  1  instruction in EX is a load
idex_rd  input  REG_W  destination register of instruction in EX
branch_taken  input  1  ID resolved a taken branch or jump this cycle
imem_stall  input  1  instruction memory not returning valid data this cycle
dmem_stall  input  1  data memory busy this cycle
halt_id  input  1  HALT opcode is in ID
pc_en  output  1  PC register write enable
if_id_en  output  1  IF/ID latch write enable
if_id_flush  output  1  IF/ID latch loads NOP instead of fetched instruction
id_ex_bubble  output  1  ID/EX loads NOP control bits
ex_mem_en  output  1  EX/MEM write enable
mem_wb_en  output  1  MEM/WB write enable
halted  output  1  pipeline drained after HALT
stall_count  output  CNT_W  cycles with pc_en=0 while in RUN or LU
flush_count  output  CNT_W  branch/jump flushes issued

Behaviour:
- All state is synchronous to clk. rst is sampled on the clock edge only.
- While rst=1:
  - Next state is RUN; lu_cnt, drain_cnt, stall_count and flush_count load 0.
  - Outputs: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_bubble=0, ex_mem_en=1, mem_wb_en=1, halted=0.
- States: RUN, LU (extended load-use stall), DRAIN, HALTED. Outputs are Mealy: a function of current state and current inputs.
- Hazard term: lu_haz = idex_memread & ((id_rs_valid & id_rs==idex_rd) | (id_rt_valid & id_rt==idex_rd)). R0 is a real register; no special case.
- RUN, evaluated by priority, first match wins:
  1. dmem_stall: every enable is 0, if_id_flush=0, id_ex_bubble=0. State and counters hold, except stall_count, which increments.
  2. lu_haz: pc_en=0, if_id_en=0, id_ex_bubble=1; ex_mem_en and mem_wb_en are 1. branch_taken and halt_id are ignored (operands are not ready). If LOADUSE_CYCLES>1, go to LU with lu_cnt=LOADUSE_CYCLES-1.
  3. branch_taken: pc_en=1, if_id_en=1, if_id_flush=1. flush_count increments. This applies regardless of imem_stall; the redirect wins.
  4. halt_id: pc_en=0, if_id_en=1, if_id_flush=1. Go to DRAIN with drain_cnt=DRAIN_CYCLES.
  5. imem_stall: pc_en=0, if_id_en=1, if_id_flush=1 (NOP into ID).
  6. Otherwise all enables are 1, if_id_flush=0, id_ex_bubble=0.
- LU:
  - Drives the same outputs as RUN priority 2, independent of lu_haz.
  - lu_cnt decrements each cycle; go to RUN after the cycle with lu_cnt==1.
  - dmem_stall overrides as in priority 1 and freezes lu_cnt.
- DRAIN:
  - pc_en=0, if_id_en=1, if_id_flush=1, id_ex_bubble=0.
  - ex_mem_en and mem_wb_en are 1 unless dmem_stall is high, which freezes them and drain_cnt.
  - drain_cnt decrements; go to HALTED after the cycle with drain_cnt==1.
  - branch_taken and halt_id are ignored.
- HALTED:
  - halted=1, pc_en=0, if_id_en=1, if_id_flush=1, ex_mem_en=1, mem_wb_en=1.
  - The only exit is rst.
- Counters:
  - stall_count increments in each RUN or LU cycle with pc_en=0.
  - flush_count increments per priority-3 cycle.
  - Both saturate at all-ones and do not wrap.
- Latency: a hazard affects outputs in the same cycle it is presented. State changes take effect next cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all inputs 0. During reset, if_id_flush=1 and halted=0. After reset, all enables are 1, flush=0, and both counters are 0.
- Load-use: idex_memread=1, idex_rd=3, id_rs=3, id_rs_valid=1, LOADUSE_CYCLES=1. That cycle shows pc_en=0, if_id_en=0, id_ex_bubble=1, and stall_count=1 next cycle. Repeat with LOADUSE_CYCLES=3 → 3 consecutive stall cycles, then RUN.
- Priority: lu_haz=1 with branch_taken=1 → bubble, no flush, flush_count unchanged. dmem_stall=1 with branch_taken=1 → all enables 0.
- Branch under imem stall: branch_taken=1, imem_stall=1 → pc_en=1, if_id_flush=1, flush_count +1.
- Halt drain: halt_id=1, with dmem_stall=1 for 1 drain cycle → halted rises exactly 4 cycles later, pc_en stays 0, rst returns to RUN.
- Saturation: CNT_W=4, hold imem_stall for 20 cycles → stall_count stays at 15.
